// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned INST_BYTES = 4;

  // One instruction-queue entry: byte address and the fetched word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    StRun  = 1'b0,
    StHalt = 1'b1
  } fetch_state_t;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [31:0] next_pc(logic [31:0] pc);
    return pc + 32'(INST_BYTES);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch unit bus: instruction-memory port, redirect request and decode handshake.
// master: the fetch unit; slave: memory/decode environment.
interface fetch_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular-buffer instruction queue with push, pop and synchronous flush.
// Push while full is accepted only when a pop happens on the same edge.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            push_i,
  input  fetch_entry_t    push_entry_i,
  input  logic            pop_i,
  output fetch_entry_t    head_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  fetch_entry_t    mem_q [Depth];
  logic            do_push;
  logic            do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy next-state; flush overrides push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed through a valid head, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential pc, combinational imem read, instruction
// queue towards decode, redirect with flush.
// Optional feature macro FETCH_MISALIGN_EN: misaligned redirects halt fetch and
// raise fetch_misalign until an aligned redirect or reset.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  fetch_if.master bus
`ifdef FETCH_MISALIGN_EN
  ,
  output logic    fetch_misalign
`endif
);

  localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);

  logic [31:0]     pc_q, pc_d;
  fetch_state_t    state_q, state_d;
  logic [31:0]     target_pc;
  logic            push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic [CntW-1:0] count;
  logic            full;
  logic            empty;

`ifdef FETCH_MISALIGN_EN
  logic            misalign_q, misalign_d;
  assign target_pc      = bus.redirect_pc;
  assign fetch_misalign = misalign_q;
`else
  // Without misalignment detection the low address bits are simply dropped.
  assign target_pc = bus.redirect_pc & 32'hFFFF_FFFC;
`endif

  assign bus.imem_addr = {2'b00, pc_q[31:2]};

  // Redirect wins over both queue operations; a handshake in that cycle is dropped.
  assign pop  = !empty && bus.out_ready && !bus.redirect_valid;
  assign push = (state_q == StRun) && !bus.redirect_valid && (!full || pop);

  assign push_entry = '{pc: pc_q, inst: bus.imem_data};

  assign bus.out_valid = (count != '0);
  assign bus.out_pc    = bus.out_valid ? head.pc   : '0;
  assign bus.out_inst  = bus.out_valid ? head.inst : '0;

  fetch_queue #(
    .Depth (QUEUE_DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (bus.redirect_valid),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty)
  );

  // Next pc and RUN/HALT state.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
`ifdef FETCH_MISALIGN_EN
    misalign_d = misalign_q;
`endif
    if (bus.redirect_valid) begin
      pc_d    = target_pc;
      state_d = StRun;
`ifdef FETCH_MISALIGN_EN
      misalign_d = (target_pc[1:0] != 2'b00);
      if (misalign_d) state_d = StHalt;
`endif
    end else if (push) begin
      pc_d = next_pc(pc_q);
    end
  end

  // pc and state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      state_q <= StRun;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

`ifdef FETCH_MISALIGN_EN
  // Sticky misalignment flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end
`endif

endmodule
